// File: rtl/pb_pkg.sv
// Shared types and sizing helpers for the pushbutton debounce front end.
package pb_pkg;

  // Debounced level of one button channel.
  typedef enum logic {
    PB_IDLE    = 1'b0,
    PB_PRESSED = 1'b1
  } pb_state_t;

  // Bits needed to hold a count from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One button slice: two-flop synchroniser, debounce counter, press/release
// edge pulses and a once-per-hold long-press pulse.
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int LONG_CYC     = 25000000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic pressed,
  output logic released,
  output logic held,
  output logic long_press
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYC);
  localparam int HOLD_W = cnt_width(LONG_CYC);
  localparam logic IDLE_LVL = ACTIVE_LOW;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);

  logic              ff1;
  logic              ff2;
  pb_state_t         samp;
  pb_state_t         state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;

  // Synchronised pin folded to press polarity, so the rest of the slice is polarity-agnostic.
  assign samp   = (ff2 != IDLE_LVL) ? PB_PRESSED : PB_IDLE;
  // The sampled level has disagreed with the debounced level for long enough.
  assign accept = (samp != state) && (db_cnt == DB_LAST);
  assign held   = (state == PB_PRESSED);

  // Two-flop synchroniser; resets to the idle pin level so a button held through reset is not seen instantly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1 <= IDLE_LVL;
      ff2 <= IDLE_LVL;
    end else begin
      ff1 <= pin;
      ff2 <= ff1;
    end
  end

  // Debounce: any sample matching the current level wipes the run-length count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PB_IDLE;
      db_cnt <= '0;
    end else if (samp == state) begin
      db_cnt <= '0;
    end else if (accept) begin
      state  <= samp;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Edge pulses registered alongside the level change so they line up with held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      pressed  <= accept && (samp == PB_PRESSED);
      released <= accept && (samp == PB_IDLE);
    end
  end

  // Hold timer saturates at LONG_CYC so long_press fires only once per hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else if (state == PB_PRESSED) begin
      if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      long_press <= (hold_cnt == HOLD_LAST);
    end else begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end
  end

endmodule

// File: rtl/pb_debounce_multi.sv
// Multi-channel pushbutton front end: NUM_PB independent debounce slices.
module pb_debounce_multi
  import pb_pkg::*;
#(
  parameter int NUM_PB       = 4,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int LONG_CYC     = 25000000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PB-1:0] PB,
  output logic [NUM_PB-1:0] pressed,
  output logic [NUM_PB-1:0] released,
  output logic [NUM_PB-1:0] held,
  output logic [NUM_PB-1:0] long_press
);

  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("pb_debounce_multi: DEBOUNCE_CYC must be >= 1");
  end
  if (LONG_CYC < 1) begin : g_bad_long
    $error("pb_debounce_multi: LONG_CYC must be >= 1");
  end

  for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW != 0)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .pin        (PB[i]),
      .pressed    (pressed[i]),
      .released   (released[i]),
      .held       (held[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Directed bench for pb_debounce_multi (4 channels, DEBOUNCE_CYC=4, LONG_CYC=20, active-low pins).
module tb_pb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] PB;
  logic [3:0] pressed, released, held, long_press;

  pb_debounce_multi #(
    .NUM_PB       (4),
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (20),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PB         (PB),
    .pressed    (pressed),
    .released   (released),
    .held       (held),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pb;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] hd;
    logic [3:0] lp;
  } vec_t;

  vec_t tbl[30];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int both_cnt = 0;
  int n_pr[4], n_rl[4], n_lp[4];
  int t_pr[4], t_rl[4], t_lp[4];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int row, input logic [3:0] pb, input logic [3:0] pr,
                         input logic [3:0] rl, input logic [3:0] hd, input logic [3:0] lp);
    tbl[row-1].pb = pb;
    tbl[row-1].pr = pr;
    tbl[row-1].rl = rl;
    tbl[row-1].hd = hd;
    tbl[row-1].lp = lp;
  endtask

  task automatic clr();
    for (int c = 0; c < 4; c++) begin
      n_pr[c] = 0; n_rl[c] = 0; n_lp[c] = 0;
      t_pr[c] = -1; t_rl[c] = -1; t_lp[c] = -1;
    end
  endtask

  // Drive the pins, advance one clock and log every pulse seen after that edge.
  task automatic tick(input logic [3:0] pb);
    PB = pb;
    @(posedge clk);
    #1;
    cyc++;
    if ((pressed & released) != 4'b0000) both_cnt++;
    for (int c = 0; c < 4; c++) begin
      if (pressed[c])    begin n_pr[c]++; t_pr[c] = cyc; end
      if (released[c])   begin n_rl[c]++; t_rl[c] = cyc; end
      if (long_press[c]) begin n_lp[c]++; t_lp[c] = cyc; end
    end
  endtask

  task automatic run(input int n, input logic [3:0] pb);
    for (int i = 0; i < n; i++) tick(pb);
  endtask

  initial begin
    int k;
    logic [3:0] p;

    // Row r is the r-th edge after reset release; a pin change applied before edge r shows at edge r+5.
    for (int r = 1;  r <= 5;  r++) set_vec(r, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    set_vec(6, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    for (int r = 7;  r <= 8;  r++) set_vec(r, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    for (int r = 9;  r <= 13; r++) set_vec(r, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    set_vec(14, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    set_vec(15, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int r = 16; r <= 20; r++) set_vec(r, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    set_vec(21, 4'b1110, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    set_vec(22, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    for (int r = 23; r <= 27; r++) set_vec(r, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    set_vec(28, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    for (int r = 29; r <= 30; r++) set_vec(r, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    clr();

    // Reset with every button already pressed.
    rst_n = 1'b0;
    PB    = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {pressed, released, held, long_press}, 16'h0000);
    rst_n = 1'b1;

    // Table: press through reset, release, then a clean press/release on ch0.
    for (int r = 1; r <= 30; r++) begin
      tick(tbl[r-1].pb);
      chk($sformatf("table_row%0d", r), {pressed, released, held, long_press},
          {tbl[r-1].pr, tbl[r-1].rl, tbl[r-1].hd, tbl[r-1].lp});
    end

    // Bounce on ch1: 2-cycle toggles never accumulate enough, then a clean settle to pressed.
    clr();
    for (int s = 0; s < 10; s++) begin
      p = 4'b1111;
      p[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
      run(2, p);
    end
    k = cyc + 1;
    run(12, 4'b1101);
    chk("bounce_press_count", n_pr[1], 1);
    chk("bounce_press_time", t_pr[1], k + 5);
    chk("bounce_no_release", n_rl[1], 0);
    run(10, 4'b1111);
    chk("bounce_release_count", n_rl[1], 1);

    // Long press on ch2: one long_press 20 cycles after pressed, never repeated.
    clr();
    k = cyc + 1;
    run(40, 4'b1011);
    run(10, 4'b1111);
    chk("long_press_count", n_pr[2], 1);
    chk("long_press_time", t_pr[2], k + 5);
    chk("long_pulse_count", n_lp[2], 1);
    chk("long_pulse_delay", t_lp[2] - t_pr[2], 20);
    chk("long_release_count", n_rl[2], 1);
    chk("long_other_channels", n_lp[0] + n_lp[1] + n_lp[3] + n_pr[0] + n_pr[1] + n_pr[3], 0);

    // Short press on ch3: press and release pulses, no long_press.
    clr();
    run(10, 4'b0111);
    run(10, 4'b1111);
    chk("short_press_count", n_pr[3], 1);
    chk("short_release_count", n_rl[3], 1);
    chk("short_press_width", t_rl[3] - t_pr[3], 10);
    chk("short_no_long", n_lp[3], 0);

    // Async reset mid-hold on ch0, then re-debounce with the button still down.
    clr();
    run(16, 4'b1110);
    chk("midhold_held", {28'd0, held}, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("midhold_async_clear", {pressed, released, held, long_press}, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    k = cyc + 1;
    run(10, 4'b1110);
    chk("after_reset_press_count", n_pr[0], 1);
    chk("after_reset_press_time", t_pr[0], k + 5);
    chk("after_reset_no_release", n_rl[0], 0);

    chk("never_both_pulses", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
